// File: rtl/cache_pkg.sv
// Shared types and default widths for the cache controller and the cache array it feeds.
package cache_pkg;

  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_STAT_WIDTH = 16;

  typedef enum logic [3:0] {
    IDLE,
    LOOKUP,
    CHECK,
    MEM_REQ,
    MEM_WAIT,
    FILL,
    WR_MEM,
    WR_CACHE,
    RESP
  } ctrl_state_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; cleared by synchronous rst.
module sat_counter #(
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  output logic [STAT_WIDTH-1:0] count
);

  logic [STAT_WIDTH-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + STAT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_ctrl.sv
// Single-outstanding CPU request controller in front of a fully-associative cache:
// read allocate on miss, write-through/write-allocate. Optional hit/miss counters under CACHE_CTRL_STATS_EN.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int STAT_WIDTH = DEF_STAT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_req_we,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
  output logic                  cpu_resp_valid,
  output logic [DATA_WIDTH-1:0] cpu_resp_data,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [DATA_WIDTH-1:0] cache_wdata,
  output logic                  cache_we,
  output logic                  cache_lookup,
  input  logic                  cache_hit,
  input  logic [DATA_WIDTH-1:0] cache_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] hit_count,
  output logic [STAT_WIDTH-1:0] miss_count
`endif
);

  ctrl_state_t           state_d, state_q;
  logic [ADDR_WIDTH-1:0] addr_d, addr_q;
  logic [DATA_WIDTH-1:0] wdata_d, wdata_q;
  logic [DATA_WIDTH-1:0] resp_data_d, resp_data_q;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    resp_data_d = resp_data_q;
    case (state_q)
      IDLE: begin
        if (cpu_req_valid) begin
          addr_d  = cpu_req_addr;
          wdata_d = cpu_req_wdata;
          state_d = cpu_req_we ? WR_MEM : LOOKUP;
        end
      end
      LOOKUP: state_d = CHECK;
      CHECK: begin
        if (cache_hit) begin
          resp_data_d = cache_rdata;
          state_d     = RESP;
        end else begin
          state_d = MEM_REQ;
        end
      end
      MEM_REQ: begin
        if (mem_req_ready) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        // Memory data is only honoured here, so a response surviving a reset is dropped.
        if (mem_resp_valid) begin
          resp_data_d = mem_resp_data;
          state_d     = FILL;
        end
      end
      FILL: state_d = RESP;
      WR_MEM: begin
        if (mem_req_ready) begin
          resp_data_d = wdata_q;
          state_d     = WR_CACHE;
        end
      end
      WR_CACHE: state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      resp_data_q <= resp_data_d;
    end
  end

  always_comb begin
    cpu_req_ready  = (state_q == IDLE);
    cpu_resp_valid = (state_q == RESP);
    cache_lookup   = (state_q == LOOKUP);
    cache_we       = (state_q == FILL) || (state_q == WR_CACHE);
    mem_req_valid  = (state_q == MEM_REQ) || (state_q == WR_MEM);
    mem_req_we     = (state_q == WR_MEM);
    // A fill writes the fetched word, which already sits in the response register.
    cache_wdata    = (state_q == WR_CACHE) ? wdata_q : resp_data_q;
  end

  assign cpu_resp_data = resp_data_q;
  assign cache_addr    = addr_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;

`ifdef CACHE_CTRL_STATS_EN
  logic hit_inc, miss_inc;

  assign hit_inc  = (state_q == CHECK) && cache_hit;
  assign miss_inc = (state_q == CHECK) && !cache_hit;

  sat_counter #(.STAT_WIDTH(STAT_WIDTH)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.STAT_WIDTH(STAT_WIDTH)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_count)
  );
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: table of single transactions against cache/memory models with a
// response scoreboard, plus held-request, reset-abort and (with CACHE_CTRL_STATS_EN) counter sequences.
module tb_cache_ctrl;

  logic        clk;
  logic        rst;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic        cpu_req_we;
  logic [9:0]  cpu_req_addr;
  logic [15:0] cpu_req_wdata;
  logic        cpu_resp_valid;
  logic [15:0] cpu_resp_data;
  logic [9:0]  cache_addr;
  logic [15:0] cache_wdata;
  logic        cache_we;
  logic        cache_lookup;
  logic        cache_hit;
  logic [15:0] cache_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [9:0]  mem_req_addr;
  logic [15:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [15:0] mem_resp_data;
`ifdef CACHE_CTRL_STATS_EN
  logic [1:0]  hit_count;
  logic [1:0]  miss_count;
`endif

  cache_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .STAT_WIDTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_req_we     (cpu_req_we),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_wdata  (cpu_req_wdata),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_data  (cpu_resp_data),
    .cache_addr     (cache_addr),
    .cache_wdata    (cache_wdata),
    .cache_we       (cache_we),
    .cache_lookup   (cache_lookup),
    .cache_hit      (cache_hit),
    .cache_rdata    (cache_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
`ifdef CACHE_CTRL_STATS_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count)
`endif
  );

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [15:0] wdata;
    logic        hit;
    logic [15:0] crdata;
    int          stall;
    int          lat;
    logic [15:0] mdata;
    logic [15:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t        vecs[7];
  logic [15:0] sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  // Environment knobs for the cache and memory models.
  logic        env_hit    = 1'b0;
  logic [15:0] env_crdata = 16'h0;
  int          env_stall  = 0;
  int          env_lat    = 1;
  logic [15:0] env_mdata  = 16'h0;

  // Observations gathered by the models.
  int          mem_acc    = 0;
  int          mem_wr_cnt = 0;
  logic [9:0]  m_addr     = '0;
  logic        m_we       = 1'b0;
  logic [15:0] m_wdata    = '0;
  int          mresp_cnt  = 0;
  int          drop_err   = 0;
  int          cwe_cnt    = 0;
  logic [9:0]  c_addr     = '0;
  logic [15:0] c_wdata    = '0;
  int          resp_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // Cache array model: hit/data answer in the cycle after a lookup strobe.
  initial begin
    logic lk_prev;
    lk_prev     = 1'b0;
    cache_hit   = 1'b0;
    cache_rdata = 16'h0BAD;
    forever begin
      @(negedge clk);
      cache_hit   = lk_prev & env_hit;
      cache_rdata = lk_prev ? (env_hit ? env_crdata : 16'hDEAD) : 16'h0BAD;
      lk_prev     = cache_lookup;
    end
  end

  // Backing memory model with programmable accept stall and read latency.
  initial begin
    int          stall_cnt, pend_cnt;
    logic [15:0] pend_data;
    logic        wait_valid;
    stall_cnt      = 0;
    pend_cnt       = 0;
    pend_data      = '0;
    wait_valid     = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 16'hBAD0;
    forever begin
      @(negedge clk);
      if (wait_valid && !mem_req_valid) drop_err++;
      mem_resp_valid = 1'b0;
      mem_resp_data  = 16'hBAD0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = pend_data;
          mresp_cnt++;
        end
      end
      mem_req_ready = 1'b0;
      wait_valid    = 1'b0;
      if (mem_req_valid) begin
        if (stall_cnt < env_stall) begin
          stall_cnt++;
          wait_valid = 1'b1;
        end else begin
          mem_req_ready = 1'b1;
          stall_cnt     = 0;
          mem_acc++;
          m_addr  = mem_req_addr;
          m_we    = mem_req_we;
          m_wdata = mem_req_wdata;
          if (mem_req_we) begin
            mem_wr_cnt++;
          end else begin
            pend_cnt  = env_lat;
            pend_data = env_mdata;
          end
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every completion pulse; also records cache writes.
  initial begin
    forever begin
      @(negedge clk);
      if (cache_we) begin
        cwe_cnt++;
        c_addr  = cache_addr;
        c_wdata = cache_wdata;
      end
      if (cpu_resp_valid) begin
        resp_cnt++;
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_resp: got response data %0h, expected no response", cpu_resp_data);
        end else begin
          check("resp_data", cpu_resp_data, sb_q.pop_front());
        end
      end
    end
  end

  task automatic clear_obs();
    mem_acc    = 0;
    mem_wr_cnt = 0;
    cwe_cnt    = 0;
    resp_cnt   = 0;
    mresp_cnt  = 0;
  endtask

  task automatic set_env(input vec_t v);
    env_hit    = v.hit;
    env_crdata = v.crdata;
    env_stall  = v.stall;
    env_lat    = v.lat;
    env_mdata  = v.mdata;
  endtask

  task automatic run_vec(input vec_t v);
    int cyc, lk_n, lk_cyc;
    bit done, exp_mem, exp_cwe;
    set_env(v);
    clear_obs();
    @(negedge clk);
    check("ready_idle", cpu_req_ready, 1);
    cpu_req_valid = 1'b1;
    cpu_req_we    = v.we;
    cpu_req_addr  = v.addr;
    cpu_req_wdata = v.wdata;
    sb_q.push_back(v.exp_data);
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
    cpu_req_addr  = 10'h3A5;
    cpu_req_wdata = 16'h6666;
    cyc = 0; lk_n = 0; lk_cyc = 0; done = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cache_lookup) begin
        lk_n++;
        if (lk_cyc == 0) lk_cyc = cyc;
      end
      if (cpu_resp_valid) done = 1'b1;
    end
    #1;
    exp_mem = v.we || !v.hit;
    exp_cwe = v.we || !v.hit;
    check("latency", cyc, v.exp_lat);
    check("lookup_count", lk_n, v.we ? 0 : 1);
    if (!v.we) check("lookup_cycle", lk_cyc, 1);
    check("mem_req_count", mem_acc, exp_mem ? 1 : 0);
    if (exp_mem) begin
      check("mem_req_addr", m_addr, v.addr);
      check("mem_req_we", m_we, v.we);
      if (v.we) check("mem_req_wdata", m_wdata, v.wdata);
    end
    check("cache_we_count", cwe_cnt, exp_cwe ? 1 : 0);
    if (exp_cwe) begin
      check("cache_addr", c_addr, v.addr);
      check("cache_wdata", c_wdata, v.exp_data);
    end
  endtask

  initial begin
    int cyc, bad_ready;
    bit done;

    //          we    addr     wdata     hit   crdata    stl lat mdata     exp_data  exp_lat
    vecs[0] = '{1'b0, 10'h010, 16'h0000, 1'b1, 16'hBEEF, 0,  0,  16'h0000, 16'hBEEF, 3};
    vecs[1] = '{1'b0, 10'h020, 16'h0000, 1'b0, 16'h0000, 2,  4,  16'h1234, 16'h1234, 11};
    vecs[2] = '{1'b1, 10'h030, 16'hA5A5, 1'b0, 16'h0000, 0,  1,  16'h0000, 16'hA5A5, 3};
    vecs[3] = '{1'b1, 10'h3FF, 16'hFFFF, 1'b1, 16'h1111, 3,  1,  16'h0000, 16'hFFFF, 6};
    vecs[4] = '{1'b0, 10'h000, 16'h0000, 1'b0, 16'h0000, 0,  1,  16'h0001, 16'h0001, 6};
    vecs[5] = '{1'b0, 10'h155, 16'h0000, 1'b1, 16'h5A5A, 0,  0,  16'h0000, 16'h5A5A, 3};
    vecs[6] = '{1'b0, 10'h2AA, 16'h0000, 1'b0, 16'h0000, 1,  2,  16'hC0DE, 16'hC0DE, 8};

    rst           = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = '0;
    cpu_req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", cpu_req_ready, 1);
    check("rst_resp_valid", cpu_resp_valid, 0);
    check("rst_lookup", cache_lookup, 0);
    check("rst_cache_we", cache_we, 0);
    check("rst_mem_valid", mem_req_valid, 0);
    check("rst_mem_we", mem_req_we, 0);
    check("rst_resp_data", cpu_resp_data, 0);
    check("rst_cache_addr", cache_addr, 0);
    check("rst_cache_wdata", cache_wdata, 0);
    check("rst_mem_addr", mem_req_addr, 0);
    check("rst_mem_wdata", mem_req_wdata, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Request held through a read miss: second (write) request must wait and go in exactly once.
    env_hit = 1'b0; env_stall = 0; env_lat = 2; env_mdata = 16'h4321;
    clear_obs();
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = 10'h101;
    cpu_req_wdata = 16'h0000;
    sb_q.push_back(16'h4321);
    @(posedge clk);
    #1;
    cpu_req_we    = 1'b1;
    cpu_req_addr  = 10'h0AB;
    cpu_req_wdata = 16'h5555;
    sb_q.push_back(16'h5555);
    cyc = 0; bad_ready = 0; done = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cpu_req_ready) bad_ready++;
      if (cpu_resp_valid) done = 1'b1;
    end
    check("held_first_latency", cyc, 7);
    check("held_ready_busy", bad_ready, 0);
    @(negedge clk);
    check("held_ready_after_resp", cpu_req_ready, 1);
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cpu_resp_valid) done = 1'b1;
    end
    check("held_second_latency", cyc, 3);
    repeat (8) @(negedge clk);
    #1;
    check("held_resp_count", resp_cnt, 2);
    check("held_mem_writes", mem_wr_cnt, 1);
    check("held_mem_reqs", mem_acc, 2);
    check("held_last_mem_addr", m_addr, 10'h0AB);

    // Reset while waiting on memory; the late response must have no effect.
    env_hit = 1'b0; env_stall = 0; env_lat = 12; env_mdata = 16'h7777;
    clear_obs();
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = 10'h040;
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
    cyc = 0;
    while (mem_acc == 0 && cyc < 50) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("abort_mem_accepted", mem_acc, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", cpu_req_ready, 1);
    check("abort_lookup", cache_lookup, 0);
    check("abort_cache_we", cache_we, 0);
    check("abort_mem_valid", mem_req_valid, 0);
    check("abort_resp_valid", cpu_resp_valid, 0);
    check("abort_resp_data", cpu_resp_data, 0);
    check("abort_cache_addr", cache_addr, 0);
    cwe_cnt  = 0;
    resp_cnt = 0;
    repeat (20) @(negedge clk);
    #1;
    check("abort_stale_resp_seen", mresp_cnt, 1);
    check("abort_no_cache_we", cwe_cnt, 0);
    check("abort_no_resp", resp_cnt, 0);
    check("abort_idle_after", cpu_req_ready, 1);

`ifdef CACHE_CTRL_STATS_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) run_vec(vecs[0]);
    run_vec(vecs[2]);
    run_vec(vecs[4]);
    check("stats_hit_sat", hit_count, 3);
    check("stats_miss", miss_count, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("stats_hit_clr", hit_count, 0);
    check("stats_miss_clr", miss_count, 0);
`endif

    check("scoreboard_empty", sb_q.size(), 0);
    check("mem_valid_held", drop_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Request controller that sits directly upstream of the fully-associative cache array. The CPU side talks only to this block.
- Read path: looks the address up in the cache. On a miss it fetches the word from backing memory, fills the cache, then responds.
- Write path: write-through, write-allocate. The word goes to memory and to the cache.
- Serves one request at a time, with a valid/ready request handshake and a single-cycle response pulse.

Parameters:
- ADDR_WIDTH, 10, word address width.
- DATA_WIDTH, 16, bits per word.
- STAT_WIDTH, 16, width of the hit/miss counters (used only with the optional feature).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- cpu_req_valid  in  1  request present.
- cpu_req_ready  out  1  controller can accept a request (IDLE only).
- cpu_req_we  in  1  1 = write, 0 = read.
- cpu_req_addr  in  ADDR_WIDTH  request address.
- cpu_req_wdata  in  DATA_WIDTH  write data.
- cpu_resp_valid  out  1  one-cycle completion pulse.
- cpu_resp_data  out  DATA_WIDTH  read data, or echoed write data.
- cache_addr  out  ADDR_WIDTH  address to the cache.
- cache_wdata  out  DATA_WIDTH  fill/write data to the cache.
- cache_we  out  1  cache write strobe.
- cache_lookup  out  1  cache lookup strobe.
- cache_hit  in  1  lookup result, valid the cycle after cache_lookup.
- cache_rdata  in  DATA_WIDTH  hit data, valid with cache_hit.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_we  out  1  memory write.
- mem_req_addr  out  ADDR_WIDTH  memory address.
- mem_req_wdata  out  DATA_WIDTH  memory write data.
- mem_resp_valid  in  1  memory read data valid.
- mem_resp_data  in  DATA_WIDTH  memory read data.

Behaviour:
- Reset (rst high at posedge):
  - state is IDLE; all strobes/valids are 0; cpu_resp_data, cache_addr, cache_wdata, mem_req_addr and mem_req_wdata are 0; cpu_req_ready is 1 after reset.
  - Reset mid-operation abandons the transaction.
  - A later mem_resp_valid arriving outside MEM_WAIT is ignored.
- Acceptance: in IDLE, cpu_req_ready = 1. When cpu_req_valid is also 1, latch we, addr and wdata. All downstream outputs are driven from these latched values.
- States:
  - IDLE: on accept, go to LOOKUP for a read, or WR_MEM for a write.
  - LOOKUP: cache_lookup = 1 for exactly one cycle, then CHECK.
  - CHECK: sample cache_hit.
    - Hit: register cache_rdata into cpu_resp_data, go to RESP.
    - Miss: go to MEM_REQ.
  - MEM_REQ: mem_req_valid = 1, mem_req_we = 0. Hold until mem_req_ready, then MEM_WAIT.
  - MEM_WAIT: wait for mem_resp_valid. On it, capture mem_resp_data into cpu_resp_data, go to FILL. There is no timeout.
  - FILL: cache_we = 1 for one cycle with cache_wdata = fetched data, then RESP.
  - WR_MEM: mem_req_valid = 1, mem_req_we = 1, mem_req_wdata = latched wdata. Hold until mem_req_ready, then WR_CACHE.
  - WR_CACHE: cache_we = 1 for one cycle with cache_wdata = wdata; cpu_resp_data = wdata; then RESP.
  - RESP: cpu_resp_valid = 1 for one cycle, then IDLE.
- Latency from the accept edge to the cpu_resp_valid cycle:
  - Read hit: 3 cycles.
  - Read miss: 5 + mem_req_ready stalls + memory latency.
  - Write: 3 + mem_req_ready stalls.
- Memory-side rules:
  - mem_resp_valid asserted in the same cycle as mem_req_ready is not honoured; memory latency is at least 1 cycle.
  - mem_req_valid must not drop before mem_req_ready.
- A new request is accepted at the earliest in the cycle after RESP.
- cpu_req_valid during a busy state is not accepted and is not lost: the requester holds it.
- There is no back-to-back pipelining.

Optional Feature:
- Macro: CACHE_CTRL_STATS_EN.
- With the macro defined:
  - Adds outputs hit_count and miss_count, each STAT_WIDTH wide.
  - CHECK with a hit increments hit_count; CHECK with a miss increments miss_count. Writes are not counted.
  - Both saturate at all-ones and clear on rst.
- Without the macro: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package cache_pkg holds:
  - state enum ctrl_state_t (IDLE, LOOKUP, CHECK, MEM_REQ, MEM_WAIT, FILL, WR_MEM, WR_CACHE, RESP);
  - default ADDR_WIDTH/DATA_WIDTH constants shared with the cache array.
- Sub-module sat_counter (STAT_WIDTH, inc, rst, count), instantiated twice, only under CACHE_CTRL_STATS_EN.

Test Plan:
- Read 0x010 with cache_hit=1 and cache_rdata=0xBEEF:
  - cache_lookup is high in cycle 1;
  - cpu_resp_valid is high in cycle 3 with data 0xBEEF;
  - mem_req_valid never asserts.
- Read 0x020, miss, mem_req_ready stalled 2 cycles, memory responds 0x1234 after 4 cycles:
  - one mem_req with addr 0x020;
  - FILL drives cache_we=1, cache_addr=0x020, cache_wdata=0x1234;
  - response data is 0x1234.
- Write 0x030 = 0xA5A5 with mem_req_ready=1:
  - mem_req_we=1 with addr 0x030 and wdata 0xA5A5;
  - then cache_we with the same values;
  - cpu_resp_valid at cycle 3 with data 0xA5A5.
- cpu_req_valid held high during a miss: cpu_req_ready stays 0 until the cycle after RESP; the second request is accepted exactly once.
- rst asserted during MEM_WAIT, then mem_resp_valid=1:
  - state is IDLE and all strobes are 0;
  - no cache_we and no cpu_resp_valid result from the stale response.
- With CACHE_CTRL_STATS_EN and STAT_WIDTH=2: 5 hits then 1 miss gives hit_count=3 (saturated) and miss_count=1; rst clears both to 0.
